// File: rtl/z480_fetch_if.sv
// Bus bundle between the Z480 fetch front end, icache_port and decode.
interface z480_fetch_if;
  // icache request channel
  logic        ic_req_valid;
  logic [63:0] ic_req_addr;
  logic        ic_req_ready;
  // icache response channel
  logic        ic_rsp_valid;
  logic [63:0] ic_rsp_addr;
  logic [31:0] ic_rsp_inst;
  logic        ic_rsp_fault;
  logic        ic_rsp_ready;
  // decode channel
  logic        dec_valid;
  logic [63:0] dec_pc;
  logic [31:0] dec_inst;
  logic        dec_fault;
  logic        dec_ready;

  // Fetch side
  modport master (
    output ic_req_valid, ic_req_addr, ic_rsp_ready,
    output dec_valid, dec_pc, dec_inst, dec_fault,
    input  ic_req_ready, ic_rsp_valid, ic_rsp_addr, ic_rsp_inst, ic_rsp_fault,
    input  dec_ready
  );

  // icache_port / decode side
  modport slave (
    input  ic_req_valid, ic_req_addr, ic_rsp_ready,
    input  dec_valid, dec_pc, dec_inst, dec_fault,
    output ic_req_ready, ic_rsp_valid, ic_rsp_addr, ic_rsp_inst, ic_rsp_fault,
    output dec_ready
  );
endinterface

// File: rtl/z480_fetch.sv
// Z480 instruction-fetch front end: sequential PC generation, in-flight request
// tracking, instruction queue towards decode, redirect flush and fault halt.
module z480_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned IQ_DEPTH  = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  z480_fetch_if.master bus
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW = $clog2(IQ_DEPTH + 1);
  localparam int unsigned PW = $clog2(IQ_DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic          halt_q, halt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] iq_count_q, iq_count_d;

  logic [63:0] iq_pc    [IQ_DEPTH];
  logic [31:0] iq_inst  [IQ_DEPTH];
  logic        iq_fault [IQ_DEPTH];

  logic [31:0] credit_used;
  logic        req_valid;
  logic        req_fire;
  logic        rsp_fire;
  logic        drop_hit;
  logic        push;
  logic        pop;

  // Every in-flight request owns an IQ slot, so a response can always be pushed.
  assign credit_used = 32'(outst_q) + 32'(iq_count_q);
  assign req_valid   = rst_n & fetch_en & ~redirect_valid & ~halt_q
                     & (32'(outst_q) < MAX_OUTST) & (credit_used < IQ_DEPTH);
  assign req_fire    = req_valid & bus.ic_req_ready;
  assign rsp_fire    = bus.ic_rsp_valid;
  assign drop_hit    = (drop_q != '0);
  assign push        = rsp_fire & ~drop_hit & ~redirect_valid;
  assign pop         = (iq_count_q != '0) & bus.dec_ready & ~redirect_valid;

  assign bus.ic_req_valid = req_valid;
  assign bus.ic_req_addr  = pc_q;
  assign bus.ic_rsp_ready = 1'b1;
  assign bus.dec_valid    = (iq_count_q != '0);
  assign bus.dec_pc       = iq_pc[rd_ptr_q];
  assign bus.dec_inst     = iq_inst[rd_ptr_q];
  assign bus.dec_fault    = iq_fault[rd_ptr_q];

  // Next-state: redirect overrides issue, response and decode activity.
  always_comb begin
    pc_d       = pc_q;
    outst_d    = outst_q + OW'(req_fire) - OW'(rsp_fire);
    drop_d     = drop_q;
    halt_d     = halt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    iq_count_d = iq_count_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[63:2], 2'b00};
      // Everything still in flight is stale, including a coincident response.
      drop_d     = outst_q - OW'(rsp_fire);
      halt_d     = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      iq_count_d = '0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 64'd4;
      end
      if (rsp_fire && drop_hit) begin
        drop_d = drop_q - OW'(1'b1);
      end
      if (push && bus.ic_rsp_fault) begin
        halt_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end
      iq_count_d = iq_count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      halt_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      iq_count_q <= '0;
    end else begin
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      halt_q     <= halt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      iq_count_q <= iq_count_d;
    end
  end

  // IQ payload storage; validity is tracked by the pointers and count only.
  always_ff @(posedge clk) begin
    if (push) begin
      iq_pc[wr_ptr_q]    <= bus.ic_rsp_addr;
      iq_inst[wr_ptr_q]  <= bus.ic_rsp_inst;
      iq_fault[wr_ptr_q] <= bus.ic_rsp_fault;
    end
  end

endmodule
